// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a generic pipeline stage register with a valid/ready
// handshake, a synchronous flush and a hold (stall) input.
// Optional feature macro: PIPE_STAGE_SKID_EN. When it is defined, a second
// (skid) entry is built in, so in_ready no longer depends on out_ready.
// When it is not defined, the stage has a single entry and in_ready passes
// combinationally through out_ready.
module pipe_stage_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = {DATA_WIDTH{1'b0}},
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  hold,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  flushed_cnt
);

  // Main entry: the oldest payload. Its data is RESET_DATA whenever it is empty.
  logic                  r_main_valid;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [CNT_WIDTH-1:0]  r_flushed_cnt;

  logic                  w_main_valid_next;
  logic [DATA_WIDTH-1:0] w_main_data_next;
  logic [CNT_WIDTH-1:0]  w_cnt_next;

  logic                  w_active;
  logic                  w_accept;
  logic                  w_emit;
  logic                  w_skid_valid;
  logic [1:0]            w_occ;
  logic [CNT_WIDTH:0]    w_cnt_sum;

`ifdef PIPE_STAGE_SKID_EN
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  w_skid_valid_next;
  logic [DATA_WIDTH-1:0] w_skid_data_next;

  assign w_skid_valid = r_skid_valid;
  // A fully registered ready signal: there is room as long as the skid entry is free.
  assign in_ready     = ~r_skid_valid & w_active;
`else
  assign w_skid_valid = 1'b0;
  // A single entry can take a new payload when it is empty or is draining this cycle.
  assign in_ready     = (~r_main_valid | out_ready) & w_active;
`endif

  // Flush or hold block every transfer in the current cycle.
  assign w_active  = ~hold & ~flush;
  assign out_valid = r_main_valid & w_active;
  assign out_data  = r_main_data;
  assign w_accept  = in_valid & in_ready;
  assign w_emit    = out_valid & out_ready;

  // The skid entry is only ever full while main is full, so this sum is 0..2.
  assign w_occ       = {1'b0, r_main_valid} + {1'b0, w_skid_valid};
  assign occupancy   = w_occ;
  assign flushed_cnt = r_flushed_cnt;

  // The sum is one bit wider than the counter, so a carry out means saturation.
  assign w_cnt_sum = {1'b0, r_flushed_cnt} + (CNT_WIDTH+1)'(w_occ);

  // Next state: flush has priority over hold, and hold over normal transfer.
  always_comb begin
    w_main_valid_next = r_main_valid;
    w_main_data_next  = r_main_data;
    w_cnt_next        = r_flushed_cnt;
`ifdef PIPE_STAGE_SKID_EN
    w_skid_valid_next = r_skid_valid;
    w_skid_data_next  = r_skid_data;
`endif
    if (flush) begin
      w_main_valid_next = 1'b0;
      w_main_data_next  = RESET_DATA;
`ifdef PIPE_STAGE_SKID_EN
      w_skid_valid_next = 1'b0;
      w_skid_data_next  = RESET_DATA;
`endif
      w_cnt_next = w_cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_cnt_sum[CNT_WIDTH-1:0];
    end else if (!hold) begin
`ifdef PIPE_STAGE_SKID_EN
      if (w_emit) begin
        if (r_skid_valid) begin
          // The skid entry is older than any new payload, so it moves up first.
          w_main_valid_next = 1'b1;
          w_main_data_next  = r_skid_data;
          w_skid_valid_next = w_accept;
          w_skid_data_next  = w_accept ? in_data : RESET_DATA;
        end else if (w_accept) begin
          w_main_data_next  = in_data;
        end else begin
          w_main_valid_next = 1'b0;
          w_main_data_next  = RESET_DATA;
        end
      end else if (w_accept) begin
        if (r_main_valid) begin
          w_skid_valid_next = 1'b1;
          w_skid_data_next  = in_data;
        end else begin
          w_main_valid_next = 1'b1;
          w_main_data_next  = in_data;
        end
      end
`else
      if (w_accept) begin
        w_main_valid_next = 1'b1;
        w_main_data_next  = in_data;
      end else if (w_emit) begin
        w_main_valid_next = 1'b0;
        w_main_data_next  = RESET_DATA;
      end
`endif
    end
  end

  // State registers; reset clears everything at once and counts nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid  <= 1'b0;
      r_main_data   <= RESET_DATA;
      r_flushed_cnt <= '0;
`ifdef PIPE_STAGE_SKID_EN
      r_skid_valid  <= 1'b0;
      r_skid_data   <= RESET_DATA;
`endif
    end else begin
      r_main_valid  <= w_main_valid_next;
      r_main_data   <= w_main_data_next;
      r_flushed_cnt <= w_cnt_next;
`ifdef PIPE_STAGE_SKID_EN
      r_skid_valid  <= w_skid_valid_next;
      r_skid_data   <= w_skid_data_next;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg (8-bit payload, 2-bit flush counter).
// Expectations follow the build: with PIPE_STAGE_SKID_EN defined the stage
// has two entries, otherwise one.
module tb_pipe_stage_reg;

  localparam int         DW  = 8;
  localparam int         CW  = 2;
  localparam logic [7:0] RST = 8'hE0;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          hold;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] flushed_cnt;

  int         n_cmp;
  int         n_err;
  logic [1:0] exp_cnt;

  pipe_stage_reg #(.DATA_WIDTH(DW), .RESET_DATA(RST), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .flushed_cnt(flushed_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per payload leaving the stage.
  always @(posedge clk) begin
    if (out_valid && out_ready) $display("emit data=%h", out_data);
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== RST) begin n_err++; $display("FAIL rst_out_data: got %h want %h", out_data, RST); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (flushed_cnt !== 2'd0) begin n_err++; $display("FAIL rst_flushed_cnt: got %0d want 0", flushed_cnt); end
    tick; tick;
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_stream;
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_out_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== vals[i]) begin n_err++; $display("FAIL stream_out_data[%0d]: got %h want %h", i, out_data, vals[i]); end
    end
    in_valid = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== RST) begin n_err++; $display("FAIL stream_drain_data: got %h want %h", out_data, RST); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL stream_drain_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_a: got %b want 1", in_ready); end
    tick;
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL bp_occ_a: got %0d want 1", occupancy); end
    in_data = 8'h0B;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_b: got %b want 1", in_ready); end
    tick;
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ_b: got %0d want 2", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
    in_valid = 1'b0;
`else
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_b: got %b want 0", in_ready); end
    tick;
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL bp_occ_b: got %0d want 1", occupancy); end
`endif
    out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_a: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'h0A) begin n_err++; $display("FAIL bp_data_a: got %h want 0a", out_data); end
    tick;
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_b: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'h0B) begin n_err++; $display("FAIL bp_data_b: got %h want 0b", out_data); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    tick;
`ifdef PIPE_STAGE_SKID_EN
    in_data = 8'h0B;
    tick;
    exp_cnt = 2'd2;
`else
    exp_cnt = 2'd1;
`endif
    flush   = 1'b1;
    in_data = 8'h0C;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid_during: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready_during: got %b want 0", in_ready); end
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_data !== RST) begin n_err++; $display("FAIL fl_data: got %h want %h", out_data, RST); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL fl_occ: got %0d want 0", occupancy); end
    n_cmp++; if (flushed_cnt !== exp_cnt) begin n_err++; $display("FAIL fl_cnt: got %0d want %0d", flushed_cnt, exp_cnt); end
    out_ready = 1'b1;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_no_emit_c: got %b want 0", out_valid); end
    // Flushing an empty stage discards nothing.
    flush = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    n_cmp++; if (flushed_cnt !== exp_cnt) begin n_err++; $display("FAIL fl_empty_cnt: got %0d want %0d", flushed_cnt, exp_cnt); end
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h05;
    tick;
    hold      = 1'b1;
    in_data   = 8'h06;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 0", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready); end
      tick;
      n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL hold_occ[%0d]: got %0d want 1", i, occupancy); end
      n_cmp++; if (out_data !== 8'h05) begin n_err++; $display("FAIL hold_data[%0d]: got %h want 05", i, out_data); end
    end
    n_cmp++; if (flushed_cnt !== exp_cnt) begin n_err++; $display("FAIL hold_cnt: got %0d want %0d", flushed_cnt, exp_cnt); end
    hold     = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_release_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'h05) begin n_err++; $display("FAIL hold_release_data: got %h want 05", out_data); end
    tick;
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL hold_release_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h70 + 8'(i);
      tick;
      in_valid = 1'b0;
      flush    = 1'b1;
      hold     = (i == 2);   // last round: flush must win over hold
      tick;
      flush = 1'b0;
      hold  = 1'b0;
      exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
      #1;
      n_cmp++; if (flushed_cnt !== exp_cnt) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, flushed_cnt, exp_cnt); end
      n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL sat_occ[%0d]: got %0d want 0", i, occupancy); end
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h09;
    tick;
    in_data = 8'h0A;
    tick;
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_data !== RST) begin n_err++; $display("FAIL areset_data: got %h want %h", out_data, RST); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL areset_occ: got %0d want 0", occupancy); end
    n_cmp++; if (flushed_cnt !== 2'd0) begin n_err++; $display("FAIL areset_cnt: got %0d want 0", flushed_cnt); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready: got %b want 1", in_ready); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_after: got %b want 0", out_valid); end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    exp_cnt   = 2'd0;
    flush     = 1'b0;
    hold      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_hold;
    test_saturation;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
